ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage. It extends the combinational ALU operation set with MIPS MULT/MULTU/DIV/DIVU and the MTHI/MTLO register moves. Results go to architectural HI/LO registers held inside the block. The unit takes one bit per cycle, uses a start/busy/done handshake, and accepts a pipeline flush. The hazard unit stalls MFHI/MFLO and further mul/div issue while `busy` is high.

---
 rtl/ex_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. Implements MULT/MULTU
//   (shift-add, one multiplier bit per cycle), DIV/DIVU (restoring division,
//   one quotient bit per cycle) and the MTHI/MTLO moves into the HI/LO
//   registers held inside this block.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, highest priority
//   start        issue pulse, only sampled in IDLE
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         rs / rt operands
//   flush        squashes an in-flight op or a start presented in IDLE
//   busy         high while a mul/div is in flight
//   done         one-cycle pulse, HI/LO already updated in that cycle
//   div_by_zero  qualifies done for a divide with b == 0
//   hi, lo       architectural HI/LO registers
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / growing quotient}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;  // negate product / quotient
  logic               neg_hi_q, neg_hi_d;  // negate remainder (sign of a)
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at issue time
  logic               signed_op_s;
  logic               sa_s, sb_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;

  // Datapath for one iteration
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_ext_s, div_ext_s, div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [2*WIDTH-1:0] mul_res_s;
  logic [WIDTH-1:0]   quo_res_s, rem_res_s;

  // Operand magnitudes, per-bit datapath and final sign correction
  always_comb begin
    signed_op_s = ~op[0];
    sa_s        = signed_op_s & a[WIDTH-1];
    sb_s        = signed_op_s & b[WIDTH-1];
    mag_a_s     = sa_s ? -a : a;
    mag_b_s     = sb_s ? -b : b;

    mul_sum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Bring the next dividend bit into the partial remainder and trial-subtract.
    rem_ext_s  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ext_s  = {1'b0, opnd_q};
    div_ge_s   = (rem_ext_s >= div_ext_s);
    div_diff_s = rem_ext_s - div_ext_s;
    if (div_ge_s) begin
      rem_next_s = div_diff_s[WIDTH-1:0];
    end else begin
      rem_next_s = rem_ext_s[WIDTH-1:0];
    end

    mul_res_s = neg_lo_q ? -prod_q : prod_q;
    // Remainder keeps the sign of a; with b == 0 this reproduces a exactly.
    rem_res_s = neg_hi_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    if (bzero_q) begin
      quo_res_s = {WIDTH{1'b1}};
    end else if (neg_lo_q) begin
      quo_res_s = -prod_q[WIDTH-1:0];
    end else begin
      quo_res_s = prod_q[WIDTH-1:0];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              cnt_d    = {CW{1'b0}};
              is_div_d = op[1];
              neg_lo_d = sa_s ^ sb_s;
              neg_hi_d = sa_s;
              bzero_d  = op[1] & (b == {WIDTH{1'b0}});
              if (op[1]) begin
                opnd_d  = mag_b_s;
                prod_d  = {{WIDTH{1'b0}}, mag_a_s};
                state_d = S_DIV;
              end else begin
                opnd_d  = mag_a_s;
                prod_d  = {{WIDTH{1'b0}}, mag_b_s};
                state_d = S_MUL;
              end
            end
            3'b100: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {rem_next_s, prod_q[WIDTH-2:0], div_ge_s};
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d  = rem_res_s;
            lo_d  = quo_res_s;
            dbz_d = bzero_q;
          end else begin
            hi_d = mul_res_s[2*WIDTH-1:WIDTH];
            lo_d = mul_res_s[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit. Three instances (WIDTH = 8, 16, 32) share
// the clock; each feature task takes an instance index k and drives only
// that instance. Inputs change #1 after a rising edge, outputs are sampled
// at the same point, so "after edge En" means #1 after that edge.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  reset_v, start_v, flush_v;
  logic [2:0]  op_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];

  logic        busy8, done8, dbz8, busy16, done16, dbz16, busy32, done32, dbz32;
  logic [7:0]  hi8, lo8;
  logic [15:0] hi16, lo16;
  logic [31:0] hi32, lo32;

  logic [2:0]  busy_w, done_w, dbz_w;
  logic [31:0] hi_w [3];
  logic [31:0] lo_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .op(op_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .flush(flush_v[0]),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

  ex_muldiv_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .op(op_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .flush(flush_v[1]),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16));

  ex_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .op(op_v[2]),
    .a(a_v[2]), .b(b_v[2]), .flush(flush_v[2]),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32));

  assign busy_w  = {busy32, busy16, busy8};
  assign done_w  = {done32, done16, done8};
  assign dbz_w   = {dbz32, dbz16, dbz8};
  assign hi_w[0] = {24'h000000, hi8};
  assign lo_w[0] = {24'h000000, lo8};
  assign hi_w[1] = {16'h0000, hi16};
  assign lo_w[1] = {16'h0000, lo16};
  assign hi_w[2] = hi32;
  assign lo_w[2] = lo32;

  function automatic int wd(input int k);
    return 8 << k;
  endfunction

  function automatic logic [31:0] msk(input int k);
    if (k == 2) return 32'hFFFFFFFF;
    return (32'h1 << wd(k)) - 32'h1;
  endfunction

  // Present one issue; returns #1 after the issuing edge E0.
  task automatic issue(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_v[k] = op; a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  // Number of edges until done is seen, -1 when the budget runs out.
  task automatic wait_done(input int k, output int n);
    n = -1;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(posedge clk); #1;
      if (done_w[k]) n = i;
    end
  endtask

  task automatic test_reset(input int k);
    reset_v[k] = 1'b1; op_v[k] = 3'b100; a_v[k] = 32'hA5A5A5A5; start_v[k] = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done W=%0d got %b want 0", wd(k), done_w[k]); end
    n_checks++; if (dbz_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_dbz W=%0d got %b want 0", wd(k), dbz_w[k]); end
    n_checks++; if (hi_w[k] !== 32'h0) begin n_fail++; $display("FAIL reset_hi W=%0d got %h want 0", wd(k), hi_w[k]); end
    n_checks++; if (lo_w[k] !== 32'h0) begin n_fail++; $display("FAIL reset_lo W=%0d got %h want 0", wd(k), lo_w[k]); end
    reset_v[k] = 1'b0; start_v[k] = 1'b0;
  endtask

  task automatic test_mult(input int k);
    int n;
    issue(k, 3'b000, 32'hFFFFFFFD, 32'h00000007);
    n_checks++; if (busy_w[k] !== 1'b1) begin n_fail++; $display("FAIL mult_busy W=%0d got %b want 1", wd(k), busy_w[k]); end
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL mult_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
    n_checks++; if (hi_w[k] !== (32'hFFFFFFFF & msk(k))) begin n_fail++; $display("FAIL mult_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'hFFFFFFFF & msk(k)); end
    n_checks++; if (lo_w[k] !== (32'hFFFFFFEB & msk(k))) begin n_fail++; $display("FAIL mult_lo W=%0d got %h want %h", wd(k), lo_w[k], 32'hFFFFFFEB & msk(k)); end
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done W=%0d got %b want 0", wd(k), busy_w[k]); end
    n_checks++; if (dbz_w[k] !== 1'b0) begin n_fail++; $display("FAIL mult_dbz W=%0d got %b want 0", wd(k), dbz_w[k]); end
    @(posedge clk); #1;
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse W=%0d got %b want 0", wd(k), done_w[k]); end
  endtask

  task automatic test_multu_hold(input int k);
    int n;
    op_v[k] = 3'b001; a_v[k] = 32'hFFFFFFFF; b_v[k] = 32'hFFFFFFFF; start_v[k] = 1'b1;
    @(posedge clk); #1;
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL multu_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
    n_checks++; if (hi_w[k] !== (32'hFFFFFFFE & msk(k))) begin n_fail++; $display("FAIL multu_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'hFFFFFFFE & msk(k)); end
    n_checks++; if (lo_w[k] !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo W=%0d got %h want 1", wd(k), lo_w[k]); end
    @(posedge clk); #1;
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL multu_no_second_done W=%0d got %b want 0", wd(k), done_w[k]); end
    n_checks++; if (busy_w[k] !== 1'b1) begin n_fail++; $display("FAIL multu_restart_busy W=%0d got %b want 1", wd(k), busy_w[k]); end
    start_v[k] = 1'b0;
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL multu_restart_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
  endtask

  task automatic test_div(input int k);
    int n;
    logic [31:0] most_neg;
    most_neg = 32'h1 << (wd(k) - 1);
    issue(k, 3'b010, 32'hFFFFFFF9, 32'h00000002);
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL div_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
    n_checks++; if (lo_w[k] !== (32'hFFFFFFFD & msk(k))) begin n_fail++; $display("FAIL div_lo W=%0d got %h want %h", wd(k), lo_w[k], 32'hFFFFFFFD & msk(k)); end
    n_checks++; if (hi_w[k] !== (32'hFFFFFFFF & msk(k))) begin n_fail++; $display("FAIL div_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'hFFFFFFFF & msk(k)); end
    issue(k, 3'b010, most_neg, 32'hFFFFFFFF);
    wait_done(k, n);
    n_checks++; if (lo_w[k] !== most_neg) begin n_fail++; $display("FAIL ovf_lo W=%0d got %h want %h", wd(k), lo_w[k], most_neg); end
    n_checks++; if (hi_w[k] !== 32'h0) begin n_fail++; $display("FAIL ovf_hi W=%0d got %h want 0", wd(k), hi_w[k]); end
    n_checks++; if (dbz_w[k] !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz W=%0d got %b want 0", wd(k), dbz_w[k]); end
    issue(k, 3'b011, 32'h00000005, 32'h00000000);
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL divu0_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
    n_checks++; if (lo_w[k] !== msk(k)) begin n_fail++; $display("FAIL divu0_lo W=%0d got %h want %h", wd(k), lo_w[k], msk(k)); end
    n_checks++; if (hi_w[k] !== 32'h00000005) begin n_fail++; $display("FAIL divu0_hi W=%0d got %h want 5", wd(k), hi_w[k]); end
    n_checks++; if (dbz_w[k] !== 1'b1) begin n_fail++; $display("FAIL divu0_dbz W=%0d got %b want 1", wd(k), dbz_w[k]); end
    @(posedge clk); #1;
    n_checks++; if (dbz_w[k] !== 1'b0) begin n_fail++; $display("FAIL divu0_dbz_clear W=%0d got %b want 0", wd(k), dbz_w[k]); end
    issue(k, 3'b010, 32'hFFFFFFF9, 32'h00000000);
    wait_done(k, n);
    n_checks++; if (hi_w[k] !== (32'hFFFFFFF9 & msk(k))) begin n_fail++; $display("FAIL div0_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'hFFFFFFF9 & msk(k)); end
    n_checks++; if (lo_w[k] !== msk(k)) begin n_fail++; $display("FAIL div0_lo W=%0d got %h want %h", wd(k), lo_w[k], msk(k)); end
    n_checks++; if (dbz_w[k] !== 1'b1) begin n_fail++; $display("FAIL div0_dbz W=%0d got %b want 1", wd(k), dbz_w[k]); end
  endtask

  task automatic test_move_flush(input int k);
    int seen;
    int fe;
    seen = 0;
    fe = (k == 2) ? 10 : 4;
    issue(k, 3'b100, 32'h00001234, 32'h0);
    n_checks++; if (done_w[k] !== 1'b1) begin n_fail++; $display("FAIL mthi_done W=%0d got %b want 1", wd(k), done_w[k]); end
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL mthi_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    n_checks++; if (hi_w[k] !== (32'h00001234 & msk(k))) begin n_fail++; $display("FAIL mthi_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'h00001234 & msk(k)); end
    issue(k, 3'b101, 32'h00005678, 32'h0);
    n_checks++; if (done_w[k] !== 1'b1) begin n_fail++; $display("FAIL mtlo_done W=%0d got %b want 1", wd(k), done_w[k]); end
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    n_checks++; if (lo_w[k] !== (32'h00005678 & msk(k))) begin n_fail++; $display("FAIL mtlo_lo W=%0d got %h want %h", wd(k), lo_w[k], 32'h00005678 & msk(k)); end
    @(posedge clk); #1;
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL mtlo_done_pulse W=%0d got %b want 0", wd(k), done_w[k]); end
    flush_v[k] = 1'b1;
    issue(k, 3'b100, 32'h00009999, 32'h0);
    flush_v[k] = 1'b0;
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL flush_mthi_done W=%0d got %b want 0", wd(k), done_w[k]); end
    n_checks++; if (hi_w[k] !== (32'h00001234 & msk(k))) begin n_fail++; $display("FAIL flush_mthi_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'h00001234 & msk(k)); end
    issue(k, 3'b000, 32'h00000003, 32'h00000005);
    repeat (fe - 1) begin @(posedge clk); #1; if (done_w[k]) seen++; end
    flush_v[k] = 1'b1;
    @(posedge clk); #1;
    flush_v[k] = 1'b0;
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL flush_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    repeat (wd(k) + 3) begin @(posedge clk); #1; if (done_w[k]) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done W=%0d got %0d dones want 0", wd(k), seen); end
    n_checks++; if (hi_w[k] !== (32'h00001234 & msk(k))) begin n_fail++; $display("FAIL flush_hi W=%0d got %h want %h", wd(k), hi_w[k], 32'h00001234 & msk(k)); end
    n_checks++; if (lo_w[k] !== (32'h00005678 & msk(k))) begin n_fail++; $display("FAIL flush_lo W=%0d got %h want %h", wd(k), lo_w[k], 32'h00005678 & msk(k)); end
  endtask

  task automatic test_reset_mid(input int k);
    int n;
    int re;
    re = (k == 2) ? 15 : 5;
    issue(k, 3'b011, 32'h00000064, 32'h00000007);
    repeat (re - 1) begin @(posedge clk); #1; end
    reset_v[k] = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    n_checks++; if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL rmid_done W=%0d got %b want 0", wd(k), done_w[k]); end
    n_checks++; if (hi_w[k] !== 32'h0) begin n_fail++; $display("FAIL rmid_hi W=%0d got %h want 0", wd(k), hi_w[k]); end
    n_checks++; if (lo_w[k] !== 32'h0) begin n_fail++; $display("FAIL rmid_lo W=%0d got %h want 0", wd(k), lo_w[k]); end
    reset_v[k] = 1'b0;
    issue(k, 3'b001, 32'h00000003, 32'h00000004);
    wait_done(k, n);
    n_checks++; if (n !== wd(k) + 1) begin n_fail++; $display("FAIL rmid_mul_latency W=%0d got %0d want %0d", wd(k), n, wd(k) + 1); end
    n_checks++; if (lo_w[k] !== 32'h0000000C) begin n_fail++; $display("FAIL rmid_mul_lo W=%0d got %h want c", wd(k), lo_w[k]); end
    n_checks++; if (hi_w[k] !== 32'h0) begin n_fail++; $display("FAIL rmid_mul_hi W=%0d got %h want 0", wd(k), hi_w[k]); end
  endtask

  task automatic test_reserved(input int k);
    int seen;
    seen = 0;
    issue(k, 3'b110, 32'h00000077, 32'h00000011);
    if (done_w[k]) seen++;
    n_checks++; if (busy_w[k] !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy W=%0d got %b want 0", wd(k), busy_w[k]); end
    issue(k, 3'b111, 32'h00000077, 32'h00000011);
    if (done_w[k]) seen++;
    @(posedge clk); #1;
    if (done_w[k]) seen++;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rsvd_done W=%0d got %0d dones want 0", wd(k), seen); end
    n_checks++; if (lo_w[k] !== 32'h0000000C) begin n_fail++; $display("FAIL rsvd_lo W=%0d got %h want c", wd(k), lo_w[k]); end
  endtask

  initial begin
    reset_v = 3'b111; start_v = 3'b000; flush_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      op_v[i] = 3'b000; a_v[i] = 32'h0; b_v[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      test_reset(k);
      test_mult(k);
      test_multu_hold(k);
      test_div(k);
      test_move_flush(k);
      test_reset_mid(k);
      test_reserved(k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
